// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: groups the fetch stage's memory, redirect and decode handshakes
// master: the fetch stage (drives requests and the decode-side head entry)
// slave : the environment (memory, execute redirect, decoder)
interface instruction_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;
   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_instruction, if_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, if_ready
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_instruction, if_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, if_ready
   );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC generation, credit-limited imem requests, response FIFO and redirect flush
// clk, rst_n : clock and asynchronous active-low reset
// fe         : instruction_fetch_if.master (imem request/response, redirect, decode handshake)
module instruction_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input logic               clk,
   input logic               rst_n,
   instruction_fetch_if.master fe
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int CW1 = CW + 1;
   localparam logic [CW:0] DEPTH_W = CW1'(FIFO_DEPTH);
   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
   state_t          state_q;
   logic [31:0]     pc_q, resp_pc_q;
   logic [CW-1:0]   out_q, disc_q, cnt_q, disc_d;
   logic [AW-1:0]   wr_q, rd_q;
   logic [31:0]     ins_q [FIFO_DEPTH];
   logic [31:0]     pcs_q [FIFO_DEPTH];
   logic [CW:0]     inflight;
   logic [31:0]     redir_pc;
   logic            resp, accept, push, pop;
   // responses with nothing outstanding are spurious and never counted
   assign resp     = fe.imem_resp_valid && out_q != '0;
   // credits use registered counts only; a pop frees its slot one cycle later
   assign inflight = {1'b0, out_q} + {1'b0, cnt_q};
   assign fe.imem_req_valid = state_q == RUN && !fe.redirect_valid && inflight < DEPTH_W;
   assign fe.imem_req_addr  = pc_q;
   assign accept   = fe.imem_req_valid && fe.imem_req_ready;
   assign push     = resp && state_q == RUN && !fe.redirect_valid;
   assign pop      = cnt_q != '0 && fe.if_ready && !fe.redirect_valid;
   assign disc_d   = out_q - CW'(resp);
   assign redir_pc = fe.redirect_pc & ~32'h3;
   assign fe.if_valid       = cnt_q != '0;
   assign fe.if_instruction = ins_q[rd_q];
   assign fe.if_pc          = pcs_q[rd_q];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         out_q     <= '0;
         disc_q    <= '0;
         cnt_q     <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            ins_q[i] <= '0;
            pcs_q[i] <= '0;
         end
      end else if (fe.redirect_valid) begin
         // every in-flight fetch except a same-cycle response must be drained
         state_q   <= disc_d != '0 ? FLUSH : RUN;
         pc_q      <= redir_pc;
         resp_pc_q <= redir_pc;
         out_q     <= disc_d;
         disc_q    <= disc_d;
         cnt_q     <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
      end else begin
         if (state_q == BOOT) state_q <= RUN;
         if (accept) pc_q <= pc_q + 32'd4;
         out_q <= out_q + CW'(accept) - CW'(resp);
         if (state_q == FLUSH && resp) begin
            disc_q <= disc_q - CW'(1);
            if (disc_q == CW'(1)) state_q <= RUN;
         end
         if (push) begin
            ins_q[wr_q] <= fe.imem_resp_data;
            pcs_q[wr_q] <= resp_pc_q;
            wr_q        <= wr_q + AW'(1);
            resp_pc_q   <= resp_pc_q + 32'd4;
         end
         if (pop) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table plus hand sequences for flush, redirect and reset
module tb_instruction_fetch;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ovf = 1'b0;
   int total = 0;
   int bad = 0;
   instruction_fetch_if bus();
   instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .fe(bus));
   always #5 clk = ~clk;
   always @(posedge clk)
      if (rst_n && dut.push && dut.cnt_q == 2'd2) ovf <= 1'b1;
   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        redir;
      logic [31:0] rpc;
      logic        ird;
      logic        rqv;
      logic [31:0] addr;
      logic        ifv;
      logic [31:0] ipc;
      logic [31:0] ins;
   } vec_t;
   vec_t tbl [18];
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, a, e);
      end
   endtask
   task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic redir, input logic [31:0] rpc, input logic ird);
      bus.imem_req_ready  = rdy;
      bus.imem_resp_valid = rv;
      bus.imem_resp_data  = rd;
      bus.redirect_valid  = redir;
      bus.redirect_pc     = rpc;
      bus.if_ready        = ird;
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic reset_dut(input bit check);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cyc();
      @(negedge clk);
      if (check) begin
         chk("rst_req_valid", bus.imem_req_valid, 0);
         chk("rst_if_valid", bus.if_valid, 0);
         chk("rst_addr", bus.imem_req_addr, 32'h0);
         chk("rst_if_pc", bus.if_pc, 32'h0);
         chk("rst_if_ins", bus.if_instruction, 32'h0);
      end
      cyc();
      rst_n = 1'b1;
   endtask
   initial begin
      tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
      tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0};
      tbl[2]  = '{1'b1, 1'b1, 32'hA000_0000, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, 32'h0,   32'h0};
      tbl[3]  = '{1'b1, 1'b1, 32'hA000_0004, 1'b0, 32'h0,   1'b1, 1'b0, 32'h8,   1'b1, 32'h0,   32'hA000_0000};
      tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4,   32'hA000_0004};
      tbl[5]  = '{1'b1, 1'b1, 32'hA000_0008, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b0, 32'h0,   32'h0};
      tbl[6]  = '{1'b1, 1'b1, 32'hA000_000C, 1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 32'h8,   32'hA000_0008};
      tbl[7]  = '{1'b1, 1'b1, 32'hBAD0_0000, 1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 32'h8,   32'hA000_0008};
      tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 32'h8,   32'hA000_0008};
      tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  1'b1, 32'h8,   32'hA000_0008};
      tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'hC,   32'hA000_000C};
      tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b0, 32'h0,   32'h0};
      tbl[12] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b0, 32'h0,   32'h0};
      tbl[13] = '{1'b1, 1'b1, 32'hDEAD_0000, 1'b1, 32'h103, 1'b1, 1'b0, 32'h14,  1'b0, 32'h0,   32'h0};
      tbl[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
      tbl[15] = '{1'b1, 1'b1, 32'hB000_0100, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   32'h0};
      tbl[16] = '{1'b1, 1'b1, 32'hB000_0104, 1'b0, 32'h0,   1'b1, 1'b0, 32'h108, 1'b1, 32'h100, 32'hB000_0100};
      tbl[17] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h104, 32'hB000_0104};
      reset_dut(1'b1);
      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].redir, tbl[i].rpc, tbl[i].ird);
         @(negedge clk);
         chk($sformatf("v%0d_req_valid", i), bus.imem_req_valid, tbl[i].rqv);
         chk($sformatf("v%0d_addr", i), bus.imem_req_addr, tbl[i].addr);
         chk($sformatf("v%0d_if_valid", i), bus.if_valid, tbl[i].ifv);
         if (tbl[i].ifv) begin
            chk($sformatf("v%0d_if_pc", i), bus.if_pc, tbl[i].ipc);
            chk($sformatf("v%0d_if_ins", i), bus.if_instruction, tbl[i].ins);
         end
         cyc();
      end
      // two fetches in flight with 3-cycle latency, then redirect to 0x103
      reset_dut(1'b0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cyc();
      @(negedge clk);
      chk("fl_req0_addr", bus.imem_req_addr, 32'h0);
      cyc();
      @(negedge clk);
      chk("fl_req1_addr", bus.imem_req_addr, 32'h4);
      cyc();
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h103, 1'b1);
      @(negedge clk);
      chk("fl_redir_req_valid", bus.imem_req_valid, 0);
      cyc();
      drive(1'b1, 1'b1, 32'hBAD0_0000, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("fl_flush1_req_valid", bus.imem_req_valid, 0);
      cyc();
      drive(1'b1, 1'b1, 32'hBAD0_0004, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("fl_flush2_req_valid", bus.imem_req_valid, 0);
      cyc();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("fl_resume_req_valid", bus.imem_req_valid, 1);
      chk("fl_resume_addr", bus.imem_req_addr, 32'h100);
      chk("fl_stale_dropped", bus.if_valid, 0);
      cyc();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cyc();
      cyc();
      drive(1'b0, 1'b1, 32'hC0DE_0100, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("fl_no_bypass", bus.if_valid, 0);
      cyc();
      // head valid; accept one more fetch so a redirect meets a response and a pop
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("fl_head_valid", bus.if_valid, 1);
      chk("fl_head_pc", bus.if_pc, 32'h100);
      chk("fl_head_ins", bus.if_instruction, 32'hC0DE_0100);
      chk("rd_pre_addr", bus.imem_req_addr, 32'h104);
      cyc();
      drive(1'b1, 1'b1, 32'hBADD_0104, 1'b1, 32'h200, 1'b1);
      @(negedge clk);
      chk("rd_req_valid", bus.imem_req_valid, 0);
      cyc();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("rd_fifo_empty", bus.if_valid, 0);
      // discard count was outstanding-1 = 0, so fetch resumes straight away
      chk("rd_run_req_valid", bus.imem_req_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_req_valid", i), bus.imem_req_valid, 1);
         chk($sformatf("stall%0d_addr", i), bus.imem_req_addr, 32'h200);
         cyc();
      end
      bus.imem_req_ready = 1'b1;
      cyc();
      bus.imem_req_ready = 1'b0;
      @(negedge clk);
      chk("stall_after_addr", bus.imem_req_addr, 32'h204);
      cyc();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hE000_0200;
      cyc();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cyc();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("mid_if_valid", bus.if_valid, 1);
      chk("mid_if_pc", bus.if_pc, 32'h200);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_if_valid", bus.if_valid, 0);
      chk("mid_rst_req_valid", bus.imem_req_valid, 0);
      chk("mid_rst_addr", bus.imem_req_addr, 32'h0);
      chk("mid_rst_if_pc", bus.if_pc, 32'h0);
      cyc();
      rst_n = 1'b1;
      bus.imem_req_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_boot", bus.imem_req_valid, 0);
      cyc();
      @(negedge clk);
      chk("post_rst_req_valid", bus.imem_req_valid, 1);
      chk("post_rst_addr", bus.imem_req_addr, 32'h0);
      chk("no_overflow", ovf, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
